branch_stack: RTL and testbench

- Checkpoint store for in-flight branches.
- Dispatch writes a snapshot of free list, map table and ROB tail when a branch is dispatched; the snapshot is tagged with a one-hot branch tag.
- Execute resolves branches by tag. A correct prediction frees the entry. A mispredict drives `restore_flag`, `free_list_restore`, map table and ROB tail restore outputs to FreddyList, map table and ROB. It also squashes all younger checkpoints.
- Retiring T_old registers are folded into every live snapshot so a restore never resurrects a register that was freed after the checkpoint.

---
 rtl/branch_stack_pkg.sv | 43 ++++
 rtl/branch_stack_lowest_free_sel.sv | 17 +
 rtl/branch_stack.sv | 120 ++++++++++++
 tb/tb_branch_stack.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_stack_pkg.sv
// Shared types and sizes for the branch checkpoint stack.
//   PHYS_REG_IDX       physical register index
//   BRANCH_MASK        one bit per checkpoint entry (tag / dependency mask)
//   MAP_TABLE_PACKET   full architectural-to-physical map snapshot
//   BRANCH_STACK_ENTRY one checkpoint: valid, dep_mask, free_list, map_table, rob_tail
package branch_stack_pkg;

   localparam int N                = 2;
   localparam int PHYS_REG_SZ_R10K = 64;
   localparam int PHYS_REG_SZ      = PHYS_REG_SZ_R10K;
   localparam int ARCH_REG_SZ      = 32;
   localparam int BRANCH_DEPTH     = 4;
   localparam int ROB_SZ           = 32;
   localparam int ROB_IDX_BITS     = $clog2(ROB_SZ);
   localparam int PHYS_IDX_BITS    = $clog2(PHYS_REG_SZ);
   localparam int NUM_SCALAR_BITS  = $clog2(N + 1);

   typedef logic [PHYS_IDX_BITS-1:0]           PHYS_REG_IDX;
   typedef logic [BRANCH_DEPTH-1:0]            BRANCH_MASK;
   typedef PHYS_REG_IDX [ARCH_REG_SZ-1:0]      MAP_TABLE_PACKET;

   typedef struct packed {
      logic                      valid;
      BRANCH_MASK                dep_mask;
      logic [PHYS_REG_SZ-1:0]    free_list;
      MAP_TABLE_PACKET           map_table;
      logic [ROB_IDX_BITS-1:0]   rob_tail;
   } BRANCH_STACK_ENTRY;

   // One-hot OR of the first cnt retiring T_old registers.
   function automatic logic [PHYS_REG_SZ-1:0] retire_onehot(
      input PHYS_REG_IDX [N-1:0]        regs,
      input logic [NUM_SCALAR_BITS-1:0] cnt
   );
      logic [PHYS_REG_SZ-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (NUM_SCALAR_BITS'(i) < cnt) v[regs[i]] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/branch_stack_lowest_free_sel.sv
// Priority selector: one-hot of the lowest clear bit of busy, plus all-full flag.
//   busy     in  W : occupancy bits
//   sel      out W : one-hot lowest free position (0 when full)
//   all_full out 1 : every bit of busy is set
module lowest_free_sel #(
   parameter int W = 4
) (
   input  logic [W-1:0] busy,
   output logic [W-1:0] sel,
   output logic         all_full
);

   // Adding one ripples through the trailing ones and lands on the lowest zero.
   assign sel      = ~busy & (busy + W'(1));
   assign all_full = &busy;

endmodule

// File: rtl/branch_stack.sv
// Checkpoint store for in-flight branches. Dispatch snapshots free list, map
// table and ROB tail under a one-hot tag; execute resolves by tag, freeing the
// entry on a correct prediction or restoring and squashing younger entries on
// a mispredict. Retiring T_old registers are folded into every live snapshot.
//   clock, reset                 clock / async active-high reset
//   checkpoint_*                 allocation request and snapshot contents
//   checkpoint_tag, stack_full   next free tag / no free entry
//   branch_mask                  tags of all live entries
//   resolve_*                    branch resolution by tag
//   phys_reg_retiring, num_retiring_valid  retiring T_old registers
//   restore_flag, *_restore      mispredict recovery state (combinational)
//   squash_mask, resolved_mask   tags killed / freed this cycle
module branch_stack
   import branch_stack_pkg::*;
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         checkpoint_valid,
   input  logic [PHYS_REG_SZ-1:0]       checkpoint_free_list,
   input  MAP_TABLE_PACKET              checkpoint_map_table,
   input  logic [ROB_IDX_BITS-1:0]      checkpoint_rob_tail,
   output BRANCH_MASK                   checkpoint_tag,
   output logic                         stack_full,
   output BRANCH_MASK                   branch_mask,
   input  logic                         resolve_valid,
   input  BRANCH_MASK                   resolve_tag,
   input  logic                         resolve_mispredict,
   input  PHYS_REG_IDX [N-1:0]          phys_reg_retiring,
   input  logic [NUM_SCALAR_BITS-1:0]   num_retiring_valid,
   output logic                         restore_flag,
   output logic [PHYS_REG_SZ-1:0]       free_list_restore,
   output MAP_TABLE_PACKET              map_table_restore,
   output logic [ROB_IDX_BITS-1:0]      rob_tail_restore,
   output BRANCH_MASK                   squash_mask,
   output BRANCH_MASK                   resolved_mask
);

   BRANCH_STACK_ENTRY [BRANCH_DEPTH-1:0] entries_q, entries_d;
   BRANCH_MASK                           valid_vec;
   BRANCH_STACK_ENTRY                    res_entry;
   logic [PHYS_REG_SZ-1:0]               retire_vec;
   logic                                 res_live, mispredict, correct;

   always_comb begin
      for (int i = 0; i < BRANCH_DEPTH; i++) valid_vec[i] = entries_q[i].valid;
   end

   assign branch_mask = valid_vec;
   assign retire_vec  = retire_onehot(phys_reg_retiring, num_retiring_valid);

   lowest_free_sel #(.W(BRANCH_DEPTH)) u_free_sel (
      .busy     (valid_vec),
      .sel      (checkpoint_tag),
      .all_full (stack_full)
   );

   assign res_live   = resolve_valid && (|(resolve_tag & valid_vec));
   assign mispredict = res_live && resolve_mispredict;
   assign correct    = res_live && !resolve_mispredict;

   always_comb begin
      res_entry = '0;
      for (int i = 0; i < BRANCH_DEPTH; i++) begin
         if (resolve_tag[i]) res_entry = entries_q[i];
      end
   end

   always_comb begin
      restore_flag      = 1'b0;
      free_list_restore = '0;
      map_table_restore = '0;
      rob_tail_restore  = '0;
      squash_mask       = '0;
      resolved_mask     = correct ? resolve_tag : '0;
      if (mispredict) begin
         restore_flag      = 1'b1;
         free_list_restore = res_entry.free_list | retire_vec;
         map_table_restore = res_entry.map_table;
         rob_tail_restore  = res_entry.rob_tail;
         squash_mask       = resolve_tag;
         // Anything allocated while the mispredicted branch was live is younger.
         for (int i = 0; i < BRANCH_DEPTH; i++) begin
            if (entries_q[i].valid && (|(entries_q[i].dep_mask & resolve_tag)))
               squash_mask[i] = 1'b1;
         end
      end
   end

   always_comb begin
      entries_d = entries_q;
      for (int i = 0; i < BRANCH_DEPTH; i++) begin
         if (entries_q[i].valid)
            entries_d[i].free_list = entries_q[i].free_list | retire_vec;
         if (correct) begin
            entries_d[i].dep_mask = entries_q[i].dep_mask & ~resolve_tag;
            if (resolve_tag[i]) entries_d[i].valid = 1'b0;
         end
         if (squash_mask[i]) entries_d[i].valid = 1'b0;
         // A same-cycle mispredict kills the new branch, so it is never written.
         if (checkpoint_valid && !stack_full && !mispredict && checkpoint_tag[i]) begin
            entries_d[i].valid     = 1'b1;
            entries_d[i].dep_mask  = branch_mask & ~resolved_mask;
            entries_d[i].free_list = checkpoint_free_list | retire_vec;
            entries_d[i].map_table = checkpoint_map_table;
            entries_d[i].rob_tail  = checkpoint_rob_tail;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) entries_q <= '0;
      else       entries_q <= entries_d;
   end

   // Dispatch protocol violation: allocation requested with no free entry.
   a_no_alloc_when_full: assert property (
      @(posedge clock) disable iff (reset) !(checkpoint_valid && stack_full)
   ) else $warning("branch_stack: checkpoint_valid while stack_full, request dropped");

endmodule

// File: tb/tb_branch_stack.sv
module tb_branch_stack;
   import branch_stack_pkg::*;

   logic                       clock, reset;
   logic                       checkpoint_valid;
   logic [PHYS_REG_SZ-1:0]     checkpoint_free_list;
   MAP_TABLE_PACKET            checkpoint_map_table;
   logic [ROB_IDX_BITS-1:0]    checkpoint_rob_tail;
   BRANCH_MASK                 checkpoint_tag, branch_mask, resolve_tag, squash_mask, resolved_mask;
   logic                       stack_full, resolve_valid, resolve_mispredict, restore_flag;
   PHYS_REG_IDX [N-1:0]        phys_reg_retiring;
   logic [NUM_SCALAR_BITS-1:0] num_retiring_valid;
   logic [PHYS_REG_SZ-1:0]     free_list_restore;
   MAP_TABLE_PACKET            map_table_restore;
   logic [ROB_IDX_BITS-1:0]    rob_tail_restore;

   int n_checks = 0;
   int n_fail   = 0;

   branch_stack dut (
      .clock(clock), .reset(reset),
      .checkpoint_valid(checkpoint_valid), .checkpoint_free_list(checkpoint_free_list),
      .checkpoint_map_table(checkpoint_map_table), .checkpoint_rob_tail(checkpoint_rob_tail),
      .checkpoint_tag(checkpoint_tag), .stack_full(stack_full), .branch_mask(branch_mask),
      .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
      .phys_reg_retiring(phys_reg_retiring), .num_retiring_valid(num_retiring_valid),
      .restore_flag(restore_flag), .free_list_restore(free_list_restore),
      .map_table_restore(map_table_restore), .rob_tail_restore(rob_tail_restore),
      .squash_mask(squash_mask), .resolved_mask(resolved_mask)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic        cpv;
      logic [63:0] cpfl;
      logic [4:0]  tail;
      logic        rv;
      logic [3:0]  rtag;
      logic        rmis;
      logic [1:0]  nret;
      logic [5:0]  r0, r1;
      logic [3:0]  e_tag;
      logic        e_full;
      logic [3:0]  e_bm;
      logic        e_rf;
      logic [63:0] e_fl;
      logic [4:0]  e_tail;
      logic [3:0]  e_sq;
      logic [3:0]  e_rs;
   } vec_t;

   vec_t vecs[$];
   int   vnum = 0;

   // Snapshot map table derived from the ROB tail so the restore can be predicted.
   function automatic MAP_TABLE_PACKET map_of(input logic [4:0] tail);
      MAP_TABLE_PACKET m;
      for (int a = 0; a < ARCH_REG_SZ; a++) m[a] = PHYS_REG_IDX'(a + int'(tail));
      return m;
   endfunction

   task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      checkpoint_valid     = 1'b0;
      checkpoint_free_list = '0;
      checkpoint_map_table = '0;
      checkpoint_rob_tail  = '0;
      resolve_valid        = 1'b0;
      resolve_tag          = '0;
      resolve_mispredict   = 1'b0;
      phys_reg_retiring    = '0;
      num_retiring_valid   = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      drive_idle();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic run_vecs();
      foreach (vecs[k]) begin
         @(negedge clock);
         checkpoint_valid     = vecs[k].cpv;
         checkpoint_free_list = vecs[k].cpfl;
         checkpoint_rob_tail  = vecs[k].tail;
         checkpoint_map_table = map_of(vecs[k].tail);
         resolve_valid        = vecs[k].rv;
         resolve_tag          = vecs[k].rtag;
         resolve_mispredict   = vecs[k].rmis;
         num_retiring_valid   = vecs[k].nret;
         phys_reg_retiring[0] = vecs[k].r0;
         phys_reg_retiring[1] = vecs[k].r1;
         #1;
         chk($sformatf("v%0d checkpoint_tag", vnum), 384'(checkpoint_tag), 384'(vecs[k].e_tag));
         chk($sformatf("v%0d stack_full", vnum), 384'(stack_full), 384'(vecs[k].e_full));
         chk($sformatf("v%0d branch_mask", vnum), 384'(branch_mask), 384'(vecs[k].e_bm));
         chk($sformatf("v%0d restore_flag", vnum), 384'(restore_flag), 384'(vecs[k].e_rf));
         chk($sformatf("v%0d free_list_restore", vnum), 384'(free_list_restore), 384'(vecs[k].e_fl));
         chk($sformatf("v%0d rob_tail_restore", vnum), 384'(rob_tail_restore), 384'(vecs[k].e_tail));
         chk($sformatf("v%0d map_table_restore", vnum), 384'(map_table_restore),
             vecs[k].e_rf ? 384'(map_of(vecs[k].e_tail)) : 384'(0));
         chk($sformatf("v%0d squash_mask", vnum), 384'(squash_mask), 384'(vecs[k].e_sq));
         chk($sformatf("v%0d resolved_mask", vnum), 384'(resolved_mask), 384'(vecs[k].e_rs));
         vnum++;
      end
      vecs.delete();
   endtask

   task automatic push_fill4();
      //           cpv cpfl    tl rv rtag    rm nr r0 r1  e_tag   ef e_bm    rf e_fl e_tl e_sq e_rs
      vecs.push_back('{1, 64'hF0, 1, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'hF1, 2, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b0001, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'hF2, 3, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 0, 4'b0011, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'hF3, 4, 0, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 4'b0111, 0, 0, 0, 0, 0});
   endtask

   initial begin
      drive_idle();
      reset = 1'b1;
      #12;
      chk("reset checkpoint_tag", 384'(checkpoint_tag), 384'(4'b0001));
      chk("reset branch_mask", 384'(branch_mask), 384'(0));
      chk("reset stack_full", 384'(stack_full), 384'(0));
      chk("reset restore_flag", 384'(restore_flag), 384'(0));
      @(negedge clock);
      reset = 1'b0;

      // Fill, overflow, correct resolve, reuse, and dependency-mask pruning.
      push_fill4();
      vecs.push_back('{1, 64'hF4, 5, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0010, 0, 0, 0, 0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0, 4'b0010});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b1101, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'hF5, 6, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b1101, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 1, 4'b1111, 1, 64'hF5, 6, 4'b0010, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b1101, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'hF6, 8, 1, 4'b0001, 0, 0, 0, 0, 4'b0010, 0, 4'b1101, 0, 0, 0, 0, 4'b0001});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b1110, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0100, 1, 0, 0, 0, 4'b0001, 0, 4'b1110, 1, 64'hF2, 3, 4'b1110, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      run_vecs();

      // Mispredict with younger squash, mispredict+checkpoint, retire fold, dead tags.
      do_reset();
      push_fill4();
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 1, 4'b1111, 1, 64'hF1, 2, 4'b1110, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b0001, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'hF7, 9, 1, 4'b0001, 1, 0, 0, 0, 4'b0010, 0, 4'b0001, 1, 64'hF0, 1, 4'b0001, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 64'h00, 7, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 2, 5, 9, 4'b0010, 0, 4'b0001, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 2, 5, 9, 4'b0010, 0, 4'b0001, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0001, 1, 1, 12, 33, 4'b0010, 0, 4'b0001, 1, 64'h1220, 7, 4'b0001, 0});
      vecs.push_back('{0, 64'h00, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0100, 1, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 64'h00, 0, 1, 4'b0010, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0});
      run_vecs();

      // Asynchronous reset in mid-cycle with three live entries and a pending mispredict.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkpoint_valid     = 1'b1;
         checkpoint_free_list = 64'hA0 + 64'(i);
         checkpoint_rob_tail  = 5'(i + 10);
         checkpoint_map_table = map_of(5'(i + 10));
      end
      @(negedge clock);
      drive_idle();
      resolve_valid      = 1'b1;
      resolve_tag        = 4'b0001;
      resolve_mispredict = 1'b1;
      #1;
      chk("pre-reset branch_mask", 384'(branch_mask), 384'(4'b0111));
      chk("pre-reset restore_flag", 384'(restore_flag), 384'(1));
      chk("pre-reset free_list_restore", 384'(free_list_restore), 384'(64'hA0));
      #1;
      reset = 1'b1;
      #1;
      chk("async reset branch_mask", 384'(branch_mask), 384'(0));
      chk("async reset restore_flag", 384'(restore_flag), 384'(0));
      chk("async reset checkpoint_tag", 384'(checkpoint_tag), 384'(4'b0001));
      chk("async reset squash_mask", 384'(squash_mask), 384'(0));
      @(negedge clock);
      drive_idle();
      reset = 1'b0;
      #1;
      chk("post-reset stack_full", 384'(stack_full), 384'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
